// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC transfer arbiter.
//   state_e  : handshake FSM states
//   DEF_*    : default sizing
//   rr_pick  : round-robin winner index (scan last+1, last+2, ... mod n)
package cdc_pkg;
  typedef enum logic [1:0] {IDLE, REQ_HI, WAIT_LO} state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BUS_WIDTH = 8;
  localparam int MAX_REQ       = 16;

  // req is zero-extended to MAX_REQ; only the low n bits take part.
  // Returns 0 when nothing is requesting (caller qualifies with |req).
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req,
                                 input int last, input int n);
    int  win;
    int  idx;
    bit  found;
    win   = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = last + k;
      if (idx >= n) idx -= n;  // last < n and k <= n, so one wrap suffices
      if (k <= n && !found && ((req >> idx) & MAX_REQ'(1)) != '0) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction
endpackage

// File: rtl/cdc_xfer_arbiter_if.sv
// Requester / transfer-channel bundle for cdc_xfer_arbiter.
//   master : requesters + destination side (drives REQ, DATA_IN, XFER_ACK_SYNC)
//   slave  : the arbiter (drives grants, completions and the held bus)
interface cdc_xfer_arbiter_if #(
  parameter int NUM_REQ   = cdc_pkg::DEF_NUM_REQ,
  parameter int BUS_WIDTH = cdc_pkg::DEF_BUS_WIDTH,
  parameter int ID_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]           REQ;
  logic [NUM_REQ*BUS_WIDTH-1:0] DATA_IN;
  logic [NUM_REQ-1:0]           GNT;
  logic [NUM_REQ-1:0]           DONE;
  logic [BUS_WIDTH-1:0]         XFER_DATA;
  logic [ID_W-1:0]              XFER_ID;
  logic                         XFER_REQ;
  logic                         XFER_ACK_SYNC;
  logic                         BUSY;
  logic                         ERR;

  modport master (output REQ, DATA_IN, XFER_ACK_SYNC,
                  input  GNT, DONE, XFER_DATA, XFER_ID, XFER_REQ, BUSY, ERR);
  modport slave  (input  REQ, DATA_IN, XFER_ACK_SYNC,
                  output GNT, DONE, XFER_DATA, XFER_ID, XFER_REQ, BUSY, ERR);
endinterface

// File: rtl/cdc_xfer_arbiter_rr.sv
// Combinational round-robin pick.
//   req    : request levels
//   last   : index of the previous winner (lowest priority this round)
//   any    : some request present
//   win_id : winner index, win_oh : winner one-hot (zero when !any)
module rr_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               any,
  output logic [ID_W-1:0]    win_id,
  output logic [NUM_REQ-1:0] win_oh
);
  assign any    = |req;
  assign win_id = ID_W'(rr_pick(MAX_REQ'(req), int'(last), NUM_REQ));
  assign win_oh = any ? (NUM_REQ'(1) << win_id) : '0;
endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Source-domain owner of one CDC transfer channel shared by NUM_REQ
// requesters. Grants round-robin, holds the winner's word on XFER_DATA and
// runs a four-phase REQ/ACK handshake (ACK arrives already synchronized).
//   CLK, RST : source clock, async active-high reset
//   bus      : cdc_xfer_arbiter_if.slave (REQ/DATA_IN in, GNT/DONE pulses,
//              XFER_DATA/XFER_ID/XFER_REQ toward destination, XFER_ACK_SYNC
//              back, BUSY, ERR)
// Build option CDC_XFER_TIMEOUT_EN: per-phase ACK_TIMEOUT watchdog that
// abandons a stuck phase and pulses ERR; otherwise ERR is tied low.
module cdc_xfer_arbiter
  import cdc_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int ACK_TIMEOUT = 64
) (
  input logic              CLK,
  input logic              RST,
  cdc_xfer_arbiter_if.slave bus
);
  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 xreq_q, xreq_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;

  logic                 any;
  logic [ID_W-1:0]      win_id;
  logic [NUM_REQ-1:0]   win_oh;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req    (bus.REQ),
    .last   (last_q),
    .any    (any),
    .win_id (win_id),
    .win_oh (win_oh)
  );

`ifdef CDC_XFER_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q, err_d;
  // cnt_q counts cycles already spent in the phase; fire on the last allowed one
  wire              tmo = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    id_d    = id_q;
    xreq_d  = xreq_q;
    gnt_d   = '0;
    done_d  = '0;
`ifdef CDC_XFER_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // an ack still high from a previous/aborted transfer blocks new grants
        if (!bus.XFER_ACK_SYNC && any) begin
          data_d  = bus.DATA_IN[win_id*BUS_WIDTH +: BUS_WIDTH];
          id_d    = win_id;
          xreq_d  = 1'b1;
          gnt_d   = win_oh;
          last_d  = win_id;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (bus.XFER_ACK_SYNC) begin
          xreq_d  = 1'b0;
          done_d  = NUM_REQ'(1) << id_q;
          state_d = WAIT_LO;
        end
`ifdef CDC_XFER_TIMEOUT_EN
        else if (tmo) begin
          xreq_d  = 1'b0;
          err_d   = 1'b1;
          state_d = WAIT_LO;
        end
`endif
      end
      WAIT_LO: begin
        if (!bus.XFER_ACK_SYNC) state_d = IDLE;
`ifdef CDC_XFER_TIMEOUT_EN
        else if (tmo) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      data_q  <= '0;
      id_q    <= '0;
      xreq_q  <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      id_q    <= id_d;
      xreq_q  <= xreq_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

`ifdef CDC_XFER_TIMEOUT_EN
  // restart on every phase entry; free-running value in IDLE is ignored
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_q == IDLE || state_d != state_q) cnt_q <= '0;
      else                                        cnt_q <= cnt_q + 1'b1;
    end
  end
  assign bus.ERR = err_q;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.GNT       = gnt_q;
  assign bus.DONE      = done_q;
  assign bus.XFER_DATA = data_q;
  assign bus.XFER_ID   = id_q;
  assign bus.XFER_REQ  = xreq_q;
  assign bus.BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Bench for cdc_xfer_arbiter: vector table of single transfers, plus
// sequences for continuous requests, stale ack, reset abort and timeout.
// Expected grants go into a scoreboard queue when driven; a negedge monitor
// pops and compares them as GNT/DONE appear.
module tb_cdc_xfer_arbiter;
  localparam int NR = 4, BW = 8, IW = 2, TMO = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  cdc_xfer_arbiter_if #(.NUM_REQ(NR), .BUS_WIDTH(BW), .ID_W(IW)) bus ();

  cdc_xfer_arbiter #(.NUM_REQ(NR), .BUS_WIDTH(BW), .ID_W(IW), .ACK_TIMEOUT(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  // destination model: ack follows XFER_REQ through a 4-stage synchronizer
  logic [3:0] ack_sr    = '0;
  logic       ack_force = 1'b0;
  logic       ack_en    = 1'b1;
  always @(posedge CLK) ack_sr <= {ack_sr[2:0], bus.XFER_REQ};
  assign bus.XFER_ACK_SYNC = ack_force | (ack_en & ack_sr[3]);

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [1:0] id; logic [7:0] data; } exp_t;
  exp_t       gnt_q[$];
  logic [1:0] done_q[$];
  exp_t       mon_e;
  logic [1:0] mon_id;
  bit         err_seen = 1'b0;

  always @(negedge CLK) begin
    if (bus.ERR) err_seen = 1'b1;
    if (|bus.GNT || |bus.DONE)
      chk("gnt_done_onehot", 32'($onehot(bus.GNT | bus.DONE)), 32'd1);
    if (|bus.GNT) begin
      if (gnt_q.size() == 0) chk("unexpected_gnt", 32'(bus.GNT), 32'd0);
      else begin
        mon_e = gnt_q.pop_front();
        chk("gnt",             32'(bus.GNT),       32'(4'b1 << mon_e.id));
        chk("xfer_id",         32'(bus.XFER_ID),   32'(mon_e.id));
        chk("xfer_data",       32'(bus.XFER_DATA), 32'(mon_e.data));
        chk("xfer_req_at_gnt", 32'(bus.XFER_REQ),  32'd1);
        chk("done_before_gnt", 32'(done_q.size()), 32'd0);
        done_q.push_back(mon_e.id);
      end
    end
    if (|bus.DONE) begin
      if (done_q.size() == 0) chk("unexpected_done", 32'(bus.DONE), 32'd0);
      else begin
        mon_id = done_q.pop_front();
        chk("done", 32'(bus.DONE), 32'(4'b1 << mon_id));
      end
    end
  end

  task automatic wait_gnt(output int n);
    n = 0;
    do begin @(negedge CLK); n++; end while (bus.GNT == '0 && n < 200);
    chk("gnt_in_time", 32'(|bus.GNT), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge CLK); n++; end while (bus.DONE == '0 && n < 200);
    chk("done_in_time", 32'(|bus.DONE), 32'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin @(negedge CLK); n++; end while ((bus.BUSY || bus.XFER_ACK_SYNC) && n < 200);
    chk("idle_in_time", 32'(bus.BUSY), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    gnt_q.delete();
    done_q.delete();
  endtask

  typedef struct { logic [3:0] req; logic [31:0] data; logic [1:0] id; logic [7:0] xd; } vec_t;
  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // pointer starts at 3; each row's id follows from the previous winner
    vt[0] = '{4'b0010, 32'h0000A500, 2'd1, 8'hA5};
    vt[1] = '{4'b0011, 32'h00003CC3, 2'd0, 8'hC3};
    vt[2] = '{4'b0011, 32'h00005A96, 2'd1, 8'h5A};
    vt[3] = '{4'b1001, 32'h7E000081, 2'd3, 8'h7E};
    vt[4] = '{4'b1100, 32'hF00F0000, 2'd2, 8'h0F};
    vt[5] = '{4'b0101, 32'h00110022, 2'd0, 8'h22};
    vt[6] = '{4'b1000, 32'hE7000000, 2'd3, 8'hE7};
    vt[7] = '{4'b1111, 32'h44332211, 2'd0, 8'h11};

    bus.REQ = '0;
    bus.DATA_IN = '0;
    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_gnt",  32'(bus.GNT),       32'd0);
    chk("rst_done", 32'(bus.DONE),      32'd0);
    chk("rst_data", 32'(bus.XFER_DATA), 32'd0);
    chk("rst_id",   32'(bus.XFER_ID),   32'd0);
    chk("rst_req",  32'(bus.XFER_REQ),  32'd0);
    chk("rst_busy", 32'(bus.BUSY),      32'd0);
    chk("rst_err",  32'(bus.ERR),       32'd0);
    RST = 1'b0;

    // single transfers from the table; data is scrambled after GNT
    for (int i = 0; i < 8; i++) begin
      wait_idle(n);
      @(negedge CLK);
      bus.REQ = vt[i].req;
      bus.DATA_IN = vt[i].data;
      gnt_q.push_back('{id: vt[i].id, data: vt[i].xd});
      wait_gnt(n);
      chk("gnt_latency", 32'(n), 32'd1);
      bus.REQ = '0;
      bus.DATA_IN = ~vt[i].data;
      wait_done(n);
      chk("done_latency", 32'(n), 32'd5);
      chk("data_hold_done", 32'(bus.XFER_DATA), 32'(vt[i].xd));
      wait_idle(n);
      chk("idle_latency", 32'(n), 32'd5);
      chk("data_hold_idle", 32'(bus.XFER_DATA), 32'(vt[i].xd));
    end

    // all requesting continuously: 0,1,2,3,0 with one 11-cycle transfer each
    do_reset();
    @(negedge CLK);
    bus.DATA_IN = 32'h44332211;
    bus.REQ = 4'b1111;
    gnt_q.push_back('{id: 2'd0, data: 8'h11});
    gnt_q.push_back('{id: 2'd1, data: 8'h22});
    gnt_q.push_back('{id: 2'd2, data: 8'h33});
    gnt_q.push_back('{id: 2'd3, data: 8'h44});
    gnt_q.push_back('{id: 2'd0, data: 8'h11});
    for (int k = 0; k < 5; k++) begin
      wait_gnt(n);
      chk("rr_gap", 32'(n), (k == 0) ? 32'd1 : 32'd11);
    end
    bus.REQ = '0;
    wait_done(n);
    wait_idle(n);
    chk("rr_sb_empty", 32'(gnt_q.size()), 32'd0);

    // stale ack in IDLE blocks the grant until it drops
    do_reset();
    ack_force = 1'b1;
    @(negedge CLK);
    bus.DATA_IN = 32'h000000BE;
    bus.REQ = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("stale_no_gnt", 32'(bus.GNT), 32'd0);
    end
    ack_force = 1'b0;
    gnt_q.push_back('{id: 2'd0, data: 8'hBE});
    @(negedge CLK);
    chk("stale_release_gnt", 32'(bus.GNT), 32'h1);
    bus.REQ = '0;
    wait_done(n);
    wait_idle(n);

    // reset while in REQ_HI: everything drops at once, no DONE, pointer reset
    @(negedge CLK);
    bus.DATA_IN = 32'h00C80000;
    bus.REQ = 4'b0100;
    gnt_q.push_back('{id: 2'd2, data: 8'hC8});
    wait_gnt(n);
    bus.REQ = '0;
    repeat (2) @(negedge CLK);
    chk("abort_busy_before", 32'(bus.BUSY), 32'd1);
    RST = 1'b1;
    #1;
    chk("abort_xfer_req", 32'(bus.XFER_REQ),  32'd0);
    chk("abort_gnt",      32'(bus.GNT),       32'd0);
    chk("abort_done",     32'(bus.DONE),      32'd0);
    chk("abort_busy",     32'(bus.BUSY),      32'd0);
    chk("abort_data",     32'(bus.XFER_DATA), 32'd0);
    chk("abort_id",       32'(bus.XFER_ID),   32'd0);
    done_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    // the aborted ack is still travelling back; the grant must wait for it
    bus.DATA_IN = 32'h44332211;
    bus.REQ = 4'b1111;
    gnt_q.push_back('{id: 2'd0, data: 8'h11});
    wait_gnt(n);
    bus.REQ = '0;
    wait_done(n);
    wait_idle(n);
    chk("no_err_so_far", 32'(err_seen), 32'd0);

    // ack never returns
    ack_en = 1'b0;
    @(negedge CLK);
    bus.DATA_IN = 32'h0000005C;
    bus.REQ = 4'b0001;
    gnt_q.push_back('{id: 2'd1, data: 8'h5C});  // pointer was 0 -> requester 1? no: only req 0 set
    gnt_q.delete();
    gnt_q.push_back('{id: 2'd0, data: 8'h5C});
    wait_gnt(n);
    bus.REQ = '0;
`ifdef CDC_XFER_TIMEOUT_EN
    n = 0;
    do begin @(negedge CLK); n++; end while (!bus.ERR && n < 100);
    chk("err_delay",    32'(n),            32'd16);
    chk("err_xfer_req", 32'(bus.XFER_REQ), 32'd0);
    chk("err_no_done",  32'(bus.DONE),     32'd0);
    #1 done_q.delete();
    @(negedge CLK);
    chk("err_one_pulse", 32'(bus.ERR),  32'd0);
    chk("err_to_idle",   32'(bus.BUSY), 32'd0);
    repeat (6) @(negedge CLK);
    ack_en = 1'b1;
`else
    repeat (40) @(negedge CLK);
    chk("wait_req_held", 32'(bus.XFER_REQ), 32'd1);
    chk("wait_busy",     32'(bus.BUSY),     32'd1);
    chk("no_err",        32'(err_seen),     32'd0);
    ack_en = 1'b1;
    wait_done(n);
    wait_idle(n);
`endif

    repeat (4) @(negedge CLK);
    chk("sb_gnt_empty",  32'(gnt_q.size()),  32'd0);
    chk("sb_done_empty", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
